// File: rtl/ccff_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ccff_loader_pkg
// Purpose  : Shared types and constants for the configuration-chain loader:
//            FSM state encoding, CRC-8 constants and a counter-width helper.
// Macros   : CCFF_CRC_EN (consumed by the loader; CRC constants live here)
// Revision : 1.0  initial release
// ============================================================================
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        CRC   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // Width of a counter that must hold every value 0..n inclusive.
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ccff_crc8_serial.sv
`default_nettype none
// ============================================================================
// Module   : ccff_crc8_serial
// Purpose  : Bit-serial CRC-8 (poly 0x07, init 0x00), one bit per enabled
//            clock, MSB-first shift-register form.
// Ports    : prog_clk  in   clock
//            pReset    in   synchronous active-low reset
//            clear     in   restart the CRC at its initial value
//            bit_en    in   fold bit_in into the CRC on this edge
//            bit_in    in   serial data bit
//            crc       out  current CRC value
// Macros   : instantiated only when CCFF_CRC_EN is defined
// Revision : 1.0  initial release
// ============================================================================
module ccff_crc8_serial
    import ccff_loader_pkg::*;
(
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       clear,
    input  logic       bit_en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic w_feedback;
    assign w_feedback = crc[7] ^ bit_in;

    always_ff @(posedge prog_clk) begin
        if (!pReset || clear) begin
            crc <= CRC8_INIT;
        end else if (bit_en) begin
            crc <= {crc[6:0], 1'b0} ^ (w_feedback ? CRC8_POLY : 8'h00);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_bitstream_loader
// Purpose  : Drives the head of a switch-block configuration chain. Accepts
//            bitstream words on a valid/ready port and shifts them LSB-first
//            into ccff_head, raising ccff_shift_en on every shift cycle, until
//            CHAIN_LEN bits have been sent.
// Ports    : prog_clk       in   configuration clock
//            pReset         in   synchronous active-low reset
//            start          in   begin a load (accepted in IDLE/DONE only)
//            in_data        in   bitstream word
//            in_valid       in   in_data valid
//            in_ready       out  word accepted on this cycle's edge if valid
//            ccff_head      out  serial bit into chain head
//            ccff_shift_en  out  chain shifts at the end of this cycle
//            ccff_tail      in   chain tail
//            busy           out  load in progress
//            done           out  sticky: full chain loaded
//            crc_err        out  sticky CRC mismatch (0 without CCFF_CRC_EN)
// Macros   : CCFF_CRC_EN - adds a trailing CRC-8 word check after the data
// Revision : 1.0  initial release
// ============================================================================
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 36,
    parameter int WORD_W    = 8
)
(
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);

    localparam int c_cnt_w  = count_width(CHAIN_LEN);
    localparam int c_wcnt_w = count_width(WORD_W);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(CHAIN_LEN - 1);

    state_t              r_state;
    logic [WORD_W-1:0]   r_shreg;     // bits of the current word still to go, after ccff_head
    logic [c_cnt_w-1:0]  r_bits;      // bits already shifted into the chain
    logic [c_wcnt_w-1:0] r_wleft;     // bits of the current word not yet shifted, incl. ccff_head
    logic [c_wcnt_w-1:0] w_word_bits;
    int                  w_rem;
    logic                w_start_acc;
    logic                w_unused_tail;

    // Tail is observed by the tile for debug only; nothing here depends on it.
    assign w_unused_tail = ccff_tail;

    assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));

    // The last word may carry fewer useful bits than WORD_W; the rest are dropped.
    always_comb begin
        w_rem       = CHAIN_LEN - int'(r_bits);
        w_word_bits = (w_rem < WORD_W) ? c_wcnt_w'(w_rem) : c_wcnt_w'(WORD_W);
    end

`ifdef CCFF_CRC_EN
    logic [7:0] w_crc;

    // The CRC covers exactly the bits that leave on ccff_head.
    ccff_crc8_serial u_crc (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clear    (w_start_acc),
        .bit_en   (ccff_shift_en),
        .bit_in   (ccff_head),
        .crc      (w_crc)
    );
`else
    assign crc_err = 1'b0;
`endif

    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            r_state       <= IDLE;
            r_shreg       <= '0;
            r_bits        <= '0;
            r_wleft       <= '0;
            in_ready      <= 1'b0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef CCFF_CRC_EN
            crc_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_acc) begin
                        r_state  <= LOAD;
                        r_bits   <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
`ifdef CCFF_CRC_EN
                        crc_err  <= 1'b0;
`endif
                    end
                end

                LOAD: begin
                    // in_ready is high throughout LOAD, so in_valid alone is the handshake.
                    if (in_valid) begin
                        r_state       <= SHIFT;
                        in_ready      <= 1'b0;
                        ccff_shift_en <= 1'b1;
                        ccff_head     <= in_data[0];
                        r_shreg       <= in_data >> 1;
                        r_wleft       <= w_word_bits;
                    end
                end

                SHIFT: begin
                    r_bits    <= r_bits + c_cnt_w'(1);
                    r_wleft   <= r_wleft - c_wcnt_w'(1);
                    ccff_head <= r_shreg[0];
                    r_shreg   <= r_shreg >> 1;
                    if (r_wleft == c_wcnt_w'(1)) begin
                        ccff_shift_en <= 1'b0;
                        ccff_head     <= 1'b0;
                        if (r_bits == c_last_bit) begin
`ifdef CCFF_CRC_EN
                            r_state  <= CRC;
                            in_ready <= 1'b1;
`else
                            r_state  <= DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
`endif
                        end else begin
                            r_state  <= LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end

`ifdef CCFF_CRC_EN
                CRC: begin
                    if (in_valid) begin
                        crc_err  <= (w_crc != in_data[7:0]);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                        r_state  <= DONE;
                    end
                end
`endif

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccff_bitstream_loader
// Purpose  : Self-checking bench for ccff_bitstream_loader. Expected head bits
//            are queued when a word is accepted and popped on shift cycles;
//            a behavioural chain model checks final chain content.
//            Cycle numbering: the cycle in which start is sampled is cycle 0.
// Macros   : CCFF_CRC_EN - also exercises the trailing CRC word
// Revision : 1.0  initial release
// ============================================================================
module tb_ccff_bitstream_loader;

    localparam int CL = 36;

    logic       clk = 1'b0;
    logic       pReset;
    logic       start, in_valid, in_ready, ccff_head, ccff_shift_en, busy, done, crc_err;
    logic [7:0] in_data;
    logic [CL-1:0] chain_m = '0;

    logic       start5, in_valid5, in_ready5, head5, shen5, busy5, done5, crc_err5;
    logic [7:0] in_data5;

    int         n_cmp = 0;
    int         n_err = 0;
    logic       q[$];
    int         bits_pushed = 0;
    int         n_shift = 0;
    logic [7:0] words[6];

    always #5 clk = ~clk;

    ccff_bitstream_loader dut (
        .prog_clk      (clk),
        .pReset        (pReset),
        .start         (start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (chain_m[CL-1]),
        .busy          (busy),
        .done          (done),
        .crc_err       (crc_err)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(5), .WORD_W(8)) dut5 (
        .prog_clk      (clk),
        .pReset        (pReset),
        .start         (start5),
        .in_data       (in_data5),
        .in_valid      (in_valid5),
        .in_ready      (in_ready5),
        .ccff_head     (head5),
        .ccff_shift_en (shen5),
        .ccff_tail     (1'b0),
        .busy          (busy5),
        .done          (done5),
        .crc_err       (crc_err5)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: queue the head bits of each accepted data word, pop on shifts.
    always @(negedge clk) begin
        if (pReset && in_valid && in_ready && bits_pushed < CL) begin
            int n;
            logic [7:0] w;
            w = in_data;
            n = (CL - bits_pushed < 8) ? CL - bits_pushed : 8;
            for (int k = 0; k < n; k++) q.push_back(w[k]);
            bits_pushed += n;
        end
        if (ccff_shift_en === 1'b1) begin
            if (q.size() == 0) check("head_extra_shift", 1, 0);
            else               check("head", ccff_head, q.pop_front());
            chain_m = {chain_m[CL-2:0], ccff_head};
            n_shift++;
        end
    end

`ifdef CCFF_CRC_EN
    function automatic logic [7:0] crc_of_words();
        logic [7:0] c, w;
        logic       b;
        c = 8'h00;
        for (int i = 0; i < CL; i++) begin
            w = words[i / 8];
            b = w[i % 8];
            c = c[7] ^ b ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    // One full load of words[]; crc_mode 0 = none, 1 = good CRC, 2 = bad CRC.
    task automatic run_load(input int stall_at, input int stall_len, input int glitch_at,
                            input int reset_at, input int crc_mode);
        int         idx, cyc, stalled, done_cyc, nw, exp_done;
        logic       acc;
        logic [7:0] w;
        logic [CL-1:0] exp_chain;
        nw = 5;
`ifdef CCFF_CRC_EN
        if (crc_mode != 0) begin
            words[5] = crc_of_words() ^ ((crc_mode == 2) ? 8'h01 : 8'h00);
            nw = 6;
        end
`endif
        for (int i = 0; i < CL; i++) begin
            w = words[i / 8];
            exp_chain[CL-1-i] = w[i % 8];
        end
        q.delete();
        bits_pushed = 0;
        n_shift     = 0;
        start = 1'b1;
        @(posedge clk); cyc = 1; #1;
        start = 1'b0;
        check("start_done_clr", done, 0);
        check("start_crc_clr", crc_err, 0);
        check("start_busy", busy, 1);
        check("start_ready", in_ready, 1);
        idx = 0; stalled = 0; done_cyc = -1;
        while (done_cyc < 0 && cyc < 200) begin
            in_valid = (idx < nw) && !(idx == stall_at && stalled < stall_len);
            if (idx < nw) in_data = words[idx];
            else          in_data = 8'h00;
            start  = (cyc == glitch_at);
            pReset = !(cyc == reset_at);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (idx == stall_at && stalled < stall_len && (stalled > 0 || in_ready)) begin
                check("stall_ready", in_ready, 1);
                check("stall_shift_en", ccff_shift_en, 0);
                stalled++;
            end
            @(posedge clk); cyc++; #1;
            start = 1'b0;
            if (acc) idx++;
            if (!pReset) begin
                pReset   = 1'b1;
                in_valid = 1'b0;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_shift_en", ccff_shift_en, 0);
                check("rst_ready", in_ready, 0);
                check("rst_head", ccff_head, 0);
                return;
            end
            if (done) done_cyc = cyc;
        end
        in_valid = 1'b0;
        exp_done = 42 + ((stall_at >= 0) ? stall_len : 0) + ((nw == 6) ? 1 : 0);
        check("done_cycle", done_cyc, exp_done);
        check("shift_count", n_shift, CL);
        check("queue_empty", q.size(), 0);
        check("chain_content", chain_m, exp_chain);
        check("done_busy", busy, 0);
        check("done_ready", in_ready, 0);
        check("crc_err", crc_err, (crc_mode == 2) ? 1 : 0);
    endtask

    initial begin
        int   cyc, done_cyc, n5, hs5, exp5_done, exp5_hs;
        logic q5[$];
        logic [4:0] exp5;

        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
        words[3] = 8'h00; words[4] = 8'h09; words[5] = 8'h00;
        pReset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        start5 = 1'b0; in_valid5 = 1'b0; in_data5 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ready", in_ready, 0);
        check("reset_shift_en", ccff_shift_en, 0);
        check("reset_head", ccff_head, 0);
        check("reset_crc_err", crc_err, 0);
        pReset = 1'b1;
        @(posedge clk); #1;

        run_load(-1, 0, -1, -1, 0);   // plain load
        run_load( 1, 5, -1, -1, 0);   // 5-cycle stall before word 2
        run_load(-1, 0,  5, -1, 0);   // start pulsed mid-shift, begun from DONE
        run_load(-1, 0, -1, 22, 0);   // reset while word 3 is shifting
        @(posedge clk); #1;
        check("idle_after_rst", busy, 0);
        run_load(-1, 0, -1, -1, 0);   // fresh load after reset
`ifdef CCFF_CRC_EN
        run_load(-1, 0, -1, -1, 1);
        run_load(-1, 0, -1, -1, 2);
        run_load(-1, 0, -1, -1, 1);   // crc_err cleared by new start
`endif

        // Short chain: one word, only its low five bits reach the chain.
        exp5 = 5'b10011;              // 8'hF3 bits 0..4, LSB first
        n5 = 0; hs5 = 0; done_cyc = -1;
        in_data5 = 8'hF3; in_valid5 = 1'b1; start5 = 1'b1;
        @(posedge clk); cyc = 1; #1;
        start5 = 1'b0;
        while (done_cyc < 0 && cyc < 50) begin
            @(negedge clk);
            if (in_valid5 && in_ready5) begin
                if (hs5 == 0) for (int k = 0; k < 5; k++) q5.push_back(exp5[k]);
                hs5++;
            end
            if (shen5) begin
                if (q5.size() == 0) check("head5_extra_shift", 1, 0);
                else                check("head5", head5, q5.pop_front());
                n5++;
            end
            @(posedge clk); cyc++; #1;
            if (done5) done_cyc = cyc;
        end
        in_valid5 = 1'b0;
`ifdef CCFF_CRC_EN
        exp5_done = 8; exp5_hs = 2;
`else
        exp5_done = 7; exp5_hs = 1;
`endif
        check("short_done_cycle", done_cyc, exp5_done);
        check("short_shift_count", n5, 5);
        check("short_handshakes", hs5, exp5_hs);
        check("short_busy", busy5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
